// File: rtl/booth_multiplier_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : booth_multiplier_pkg                                          |
// | Brief  : Shared constants, state encodings and Booth decode codes for  |
// |          the iterative radix-2 Booth multiplier.                       |
// | Ports  : none (package)                                                |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
package booth_multiplier_pkg;

  localparam int DATA_WIDTH = 32;
  // Booth steps per multiply; one step retires one multiplier bit.
  localparam int ITER       = DATA_WIDTH;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'd0,
    BOOTH_ADD = 2'd1,
    BOOTH_SUB = 2'd2
  } booth_op_e;

  localparam logic [4:0] ALU_OPC_ADD = 5'b00000;
  localparam logic [4:0] ALU_OPC_SUB = 5'b00001;

  // Radix-2 Booth recoding of {Q[i], Q[i-1]}.
  function automatic booth_op_e booth_decode(input logic [1:0] bits);
    booth_op_e op;
    case (bits)
      2'b01:   op = BOOTH_ADD;
      2'b10:   op = BOOTH_SUB;
      default: op = BOOTH_NOP;
    endcase
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder_subtractor.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : adder_subtractor                                              |
// | Brief  : 32-bit two's-complement adder/subtractor with signed overflow.|
// | Ports  : data_operandA/B [31:0] in, ctrl_ALUopcode [4:0] in            |
// |          (bit 0 set = subtract), data_result [31:0] out, overflow out. |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module adder_subtractor (
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic [4:0]  ctrl_ALUopcode,
  output logic [31:0] data_result,
  output logic        overflow
);

  logic        w_sub;
  logic [31:0] w_b_eff;
  logic [31:0] w_sum;

  assign w_sub   = ctrl_ALUopcode[0];
  // Subtraction as A + ~B + 1.
  assign w_b_eff = data_operandB ^ {32{w_sub}};
  assign w_sum   = data_operandA + w_b_eff + {31'd0, w_sub};

  assign data_result = w_sum;
  assign overflow    = (data_operandA[31] == w_b_eff[31]) && (w_sum[31] != data_operandA[31]);

  // Upper opcode bits select other ALU functions elsewhere; unused here.
  logic w_unused_opc;
  assign w_unused_opc = ^ctrl_ALUopcode[4:1];

endmodule
`default_nettype wire

// File: rtl/booth_multiplier.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : booth_multiplier                                              |
// | Brief  : Iterative radix-2 Booth signed multiplier, 32 steps/multiply. |
// |          Returns the low 32 product bits plus a signed-overflow flag.  |
// | Ports  : clock, reset (sync, active-low), ctrl_MULT (start),           |
// |          data_operandA (M), data_operandB (Q), data_result [31:0],     |
// |          data_exception, data_resultRDY (1-cycle pulse), busy.         |
// | Config : `define MULT_RESTART_EN lets ctrl_MULT during RUN abort and    |
// |          restart with fresh operands; otherwise it is ignored.         |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module booth_multiplier
  import booth_multiplier_pkg::*;
#(
  // Only 32 is supported: the shared adder_subtractor is fixed-width.
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

`ifdef MULT_RESTART_EN
  localparam bit RESTART_EN = 1'b1;
`else
  localparam bit RESTART_EN = 1'b0;
`endif

  state_e      state_q,  state_d;
  logic [5:0]  count_q,  count_d;
  logic [31:0] m_q,      m_d;
  // {HI[31:0], LO[31:0], q_m1}
  logic [64:0] p_q,      p_d;
  logic [31:0] result_q, result_d;
  logic        exc_q,    exc_d;

  booth_op_e   booth_op;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_sum;
  logic        alu_ovf;
  logic [31:0] hi_sel;
  logic        shift_msb;
  logic [64:0] step_p;
  logic        load;

  adder_subtractor u_adder_subtractor (
    .data_operandA  (p_q[64:33]),
    .data_operandB  (m_q),
    .ctrl_ALUopcode (alu_opcode),
    .data_result    (alu_sum),
    .overflow       (alu_ovf)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    m_d        = m_q;
    p_d        = p_q;
    result_d   = result_q;
    exc_d      = exc_q;

    booth_op   = booth_decode(p_q[1:0]);
    alu_opcode = (booth_op == BOOTH_SUB) ? ALU_OPC_SUB : ALU_OPC_ADD;
    hi_sel     = (booth_op == BOOTH_NOP) ? p_q[64:33] : alu_sum;
    // XOR with overflow recovers the true sign of the 33-bit sum, which
    // matters when M = 0x80000000 and HI - M leaves the 32-bit range.
    shift_msb  = (booth_op == BOOTH_NOP) ? hi_sel[31] : (hi_sel[31] ^ alu_ovf);
    step_p     = {shift_msb, hi_sel, p_q[32:1]};

    load = ctrl_MULT && ((state_q != RUN) || RESTART_EN);

    if (load) begin
      m_d     = data_operandA;
      p_d     = {32'd0, data_operandB, 1'b0};
      count_d = 6'd0;
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          p_d     = step_p;
          count_d = count_q + 6'd1;
          if (count_q == 6'(ITER - 1)) begin
            count_d  = 6'd0;
            state_d  = DONE;
            result_d = step_p[32:1];
            exc_d    = (step_p[64:33] != {32{step_p[32]}});
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= 6'd0;
      m_q      <= 32'd0;
      p_q      <= 65'd0;
      result_q <= 32'd0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      m_q      <= m_d;
      p_q      <= p_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == DONE);
  assign busy           = (state_q == RUN);

endmodule
`default_nettype wire

// File: tb/tb_booth_multiplier.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : tb_booth_multiplier                                           |
// | Brief  : Self-checking bench for booth_multiplier against a signed     |
// |          64-bit arithmetic reference.                                  |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module tb_booth_multiplier;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ctrl_MULT = 1'b0;
  logic [31:0] data_operandA = 32'd0;
  logic [31:0] data_operandB = 32'd0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int errors = 0;
  int checks = 0;

  booth_multiplier u_dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: exact signed product, low word, and whether it fits in 32 bits.
  task automatic ref_mult(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] lo, output logic exc);
    longint pa, pb, full;
    pa   = longint'($signed(a));
    pb   = longint'($signed(b));
    full = pa * pb;
    lo   = full[31:0];
    exc  = (full != longint'($signed(full[31:0])));
  endtask

  // Edge count convention: the start edge is edge 1, so RDY is expected
  // to be visible after edge 33.
  task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] exp_r;
    logic        exp_e;
    int          edges;
    bit          seen;
    ref_mult(a, b, exp_r, exp_e);
    @(negedge clock);
    ctrl_MULT = 1'b1; data_operandA = a; data_operandB = b;
    @(posedge clock);
    edges = 1;
    @(negedge clock);
    ctrl_MULT = 1'b0; data_operandA = $urandom; data_operandB = $urandom;
    check1({tag, ".busy_start"}, busy, 1'b1);
    seen = 0;
    while (edges < 40 && !seen) begin
      if (data_resultRDY) seen = 1;
      else begin
        @(posedge clock); edges++;
        @(negedge clock);
      end
    end
    check1({tag, ".rdy_seen"}, seen, 1'b1);
    check_int({tag, ".latency"}, edges, 33);
    check32({tag, ".result"}, data_result, exp_r);
    check1({tag, ".exception"}, data_exception, exp_e);
    check1({tag, ".busy_done"}, busy, 1'b0);
    @(negedge clock);
    check1({tag, ".rdy_pulse"}, data_resultRDY, 1'b0);
    check32({tag, ".result_hold"}, data_result, exp_r);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int          edges;
    int          rdy_cnt;
    int          first_rdy;
    logic [31:0] first_val;
    int          exp_edge;
    logic [31:0] exp_val;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check32("reset.result", data_result, 32'd0);
    check1("reset.exception", data_exception, 1'b0);
    check1("reset.rdy", data_resultRDY, 1'b0);
    check1("reset.busy", busy, 1'b0);
    reset = 1'b1;

    // Directed cases
    run_mult(32'd3, 32'd5, "t1_3x5");
    run_mult(32'hFFFF_FFF9, 32'd6, "t2_m7x6");
    run_mult(32'h7FFF_FFFF, 32'd2, "t3_max_x2");
    run_mult(32'h8000_0000, 32'hFFFF_FFFF, "t3_min_xm1");
    run_mult(32'h8000_0000, 32'h8000_0000, "t4_min_xmin");
    run_mult(32'h8000_0000, 32'd1, "t4_min_x1");
    run_mult(32'd0, 32'hDEAD_BEEF, "t_zero");

    // Randomised operands, mixing full-range and small signed values
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 2 == 1) begin
        ra = 32'($signed(ra[15:0]));
        rb = 32'($signed(rb[11:0]));
      end
      run_mult(ra, rb, "rand");
    end

    // Reset mid-RUN: outputs clear and the aborted op never signals RDY
    run_mult(32'd3, 32'd5, "pre_reset");
    @(negedge clock);
    ctrl_MULT = 1'b1; data_operandA = 32'd3; data_operandB = 32'd5;
    @(posedge clock);
    edges = 1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    while (edges < 10) begin
      @(posedge clock); edges++;
    end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check32("t5.reset_result", data_result, 32'd0);
    check1("t5.reset_exception", data_exception, 1'b0);
    check1("t5.reset_rdy", data_resultRDY, 1'b0);
    check1("t5.reset_busy", busy, 1'b0);
    reset = 1'b1;
    rdy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (data_resultRDY) rdy_cnt++;
    end
    check_int("t5.no_rdy_after_abort", rdy_cnt, 0);
    run_mult(32'd4, 32'd4, "t5_4x4");

    // Start during RUN: ignored by default, restarts when enabled
`ifdef MULT_RESTART_EN
    exp_edge = 45; exp_val = 32'd4;
`else
    exp_edge = 33; exp_val = 32'd15;
`endif
    @(negedge clock);
    ctrl_MULT = 1'b1; data_operandA = 32'd3; data_operandB = 32'd5;
    @(posedge clock);
    edges = 1; rdy_cnt = 0; first_rdy = 0; first_val = 32'd0;
    while (edges < 60) begin
      @(negedge clock);
      ctrl_MULT = (edges == 12);
      if (edges == 12) begin
        data_operandA = 32'd2; data_operandB = 32'd2;
      end
      if (data_resultRDY) begin
        rdy_cnt++;
        if (first_rdy == 0) begin
          first_rdy = edges;
          first_val = data_result;
        end
      end
      @(posedge clock); edges++;
    end
    @(negedge clock);
    ctrl_MULT = 1'b0;
    check_int("t6.rdy_edge", first_rdy, exp_edge);
    check32("t6.result", first_val, exp_val);
    check_int("t6.rdy_count", rdy_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/booth_multiplier.md
Name: booth_multiplier

Overview:
Iterative radix-2 Booth signed multiplier for the execute stage. It sits beside the ALU and reuses one adder_subtractor instance as its accumulate/subtract datapath. It delivers the low 32 bits of the product plus an overflow exception, multdiv-style. Each multiply takes 32 iterations.

Parameters:
WIDTH, 32, operand/result width; only 32 is supported (adder_subtractor is fixed at 32 bits).
ITER, 32, Booth steps per multiply; always equal to WIDTH.

Ports:
clock  input  1  single clock; all state updates on the rising edge.
reset  input  1  synchronous, active-low; sampled on the rising edge of clock.
ctrl_MULT  input  1  start pulse; operands are sampled on the same edge.
data_operandA  input  32  multiplicand M (two's complement).
data_operandB  input  32  multiplier Q (two's complement).
data_result  output  32  low 32 bits of A*B.
data_exception  output  1  high when the full 64-bit product does not fit in signed 32 bits.
data_resultRDY  output  1  one-cycle pulse marking valid result/exception.
busy  output  1  high while iterating.

Behaviour:
- Interface: one clock, `clock`; reset `reset` is synchronous and active-low.
- Reset (reset=0 at an edge): state←IDLE, count←0, product register←0. data_result=0, data_exception=0, data_resultRDY=0, busy=0. Reset overrides any other input in the same cycle, including mid-RUN; the aborted operation produces no RDY pulse.
- Internal registers:
  - M: 32 bits.
  - P: 65 bits, laid out {HI[31:0], LO[31:0], q_m1}.
  - count: 6 bits.
- State machine:
  - IDLE/DONE + ctrl_MULT=1: latch M←data_operandA, P←{32'b0, data_operandB, 1'b0}, count←0, go to RUN.
  - RUN: one Booth step per edge.
    - Bits P[1:0]=01: HI + M. Bits 10: HI − M, with ctrl_ALUopcode nonzero. Bits 00/11: HI unchanged; the adder output is ignored.
    - Then arithmetic shift right of the 65-bit value {S, LO, q_m1} by 1, where S is the selected HI value.
    - Shifted-in MSB = S[31] XOR adder overflow when an add/sub was selected, else S[31]. This keeps M=0x80000000 correct.
    - count increments.
  - After the 32nd step (count reaches 31 and wraps), go to DONE.
  - DONE (one cycle): data_resultRDY=1, busy=0; then return to IDLE unless ctrl_MULT=1.
- Latency: ctrl_MULT sampled at edge E0 → steps on E1..E32 → data_resultRDY high in the cycle after E32 (33 cycles).
- busy is high from the cycle after E0 through the cycle containing E32.
- data_result is driven from LO (P[32:1]) and holds until the next start's E32.
- data_exception = (HI != {32{LO[31]}}), registered together with the result and held like it.
- ctrl_MULT while in RUN is ignored (see optional feature). ctrl_MULT in DONE starts a new operation on that edge; the RDY pulse for the finished result still occurs.
- Operand inputs are don't-care except on the start edge.

Optional Feature:
MULT_RESTART_EN
- Defined: ctrl_MULT=1 during RUN aborts the current operation, reloads operands, resets count to 0 and stays in RUN. The aborted operation gives no RDY pulse; the result appears 33 cycles after the restart edge.
- Undefined: ctrl_MULT during RUN is ignored and the original operation completes unchanged.

Decomposition:
- Shared package: state encodings (IDLE, RUN, DONE), ITER constant, Booth decode codes (NOP/ADD/SUB).
- Sub-module: instantiate the existing adder_subtractor (operands HI and M; ctrl_ALUopcode driven 5'b00001 for SUB, 5'b00000 otherwise).
- No new sub-module is required.

Test Plan:
1. A=3, B=5, pulse ctrl_MULT → data_resultRDY exactly 33 cycles later; data_result=15, data_exception=0.
2. A=−7 (0xFFFFFFF9), B=6 → data_result=0xFFFFFFD6 (−42), data_exception=0.
3. A=0x7FFFFFFF, B=2 → data_result=0xFFFFFFFE, data_exception=1. A=0x80000000, B=0xFFFFFFFF → data_result=0x80000000, data_exception=1.
4. A=0x80000000, B=0x80000000 → data_result=0, data_exception=1 (checks the S XOR overflow shift-in). A=0x80000000, B=1 → data_result=0x80000000, data_exception=0.
5. Start A=3, B=5; assert reset=0 at cycle 10 → all outputs 0, busy=0, no RDY pulse. Then start A=4, B=4 → 16 at +33.
6. Start A=3, B=5; pulse ctrl_MULT with A=2, B=2 at cycle 12.
   - Undefined macro: result 15 at cycle 33.
   - MULT_RESTART_EN defined: no RDY at cycle 33; result 4 at cycle 45.
